interconnect_matrix: RTL and testbench

//  Parametrised successor of the single-LUT-input interconnect mux.

---
 rtl/interconnect_matrix.sv | 79 +++++++
 tb/tb_interconnect_matrix.sv | 138 +++++++++++++
 2 files changed

// File: rtl/interconnect_matrix.sv
// interconnect_matrix: serially configured NUM_SRC-to-NUM_OUT routing matrix feeding the registered LUT inputs of one CLB
module interconnect_matrix #(
  parameter int NUM_SRC = 40,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_b_i,
  input  logic               cfg_start_i,
  input  logic               cfg_valid_i,
  input  logic               cfg_bit_i,
  output logic               cfg_ready_o,
  output logic               cfg_done_o,
  output logic               cfg_err_o,
  input  logic               route_en_i,
  input  logic [NUM_SRC-1:0] src_in_i,
  output logic [NUM_OUT-1:0] lut_inp_o
);
  localparam int TOT_W = NUM_OUT * SEL_W;
  localparam int CW    = $clog2(TOT_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_t;
  state_t             state_q, state_d;
  logic [TOT_W-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               loaded_q, loaded_d, err_q, err_d;
  logic [NUM_OUT-1:0] lut_q, lut_d;
  logic               start_ok, shift, last, commit, bad;
  function automatic logic pick(input logic [SEL_W-1:0] s, input logic [NUM_SRC-1:0] v);
    pick = 1'b0;
    for (int j = 0; j < NUM_SRC; j++)
      if (int'(s) == j) pick = v[j];
  endfunction
  assign start_ok = cfg_start_i && state_q != COMMIT;
  assign shift    = state_q == LOAD && cfg_valid_i && !cfg_start_i;
  assign last     = shift && cnt_q == CW'(TOT_W - 1);
  assign commit   = state_q == COMMIT;
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < NUM_OUT; k++)
      bad = bad | (int'(shadow_q[k*SEL_W +: SEL_W]) >= NUM_SRC);
  end
  always_comb begin
    state_d  = start_ok ? LOAD : last ? COMMIT : commit ? RUN : state_q;
    shadow_d = shift ? {shadow_q[TOT_W-2:0], cfg_bit_i} : shadow_q;
    cnt_d    = (start_ok || commit) ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    active_d = commit ? shadow_q : active_q;
    loaded_d = loaded_q | commit;
    err_d    = start_ok ? 1'b0 : err_q | (commit & bad);
  end
  // Outputs keep following the old active config until the commit edge.
  always_comb begin
    lut_d = lut_q;
    for (int k = 0; k < NUM_OUT; k++)
      lut_d[k] = !loaded_q ? 1'b0 : !route_en_i ? lut_q[k] : pick(active_q[k*SEL_W +: SEL_W], src_in_i);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      lut_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      lut_q    <= lut_d;
    end
  end
  assign cfg_ready_o = state_q == LOAD;
  assign cfg_done_o  = commit;
  assign cfg_err_o   = err_q;
  assign lut_inp_o   = lut_q;
endmodule

// File: tb/tb_interconnect_matrix.sv
// tb_interconnect_matrix: randomized scoreboard bench against a bit-queue reference model of the routing matrix
module tb_interconnect_matrix;
  localparam int NS = 40;
  localparam int NO = 4;
  localparam int SW = 6;
  localparam int TW = NO * SW;
  typedef logic [NO+2:0] exp_t;
  logic          clk = 1'b0;
  logic          rst_b = 1'b0, start = 1'b0, valid = 1'b0, bitv = 1'b0, ren = 1'b1;
  logic [NS-1:0] src = '0;
  logic          ready, done, err;
  logic [NO-1:0] lut;
  logic          g_rst = 1'b0, g_ren = 1'b1;
  exp_t          expq[$];
  int            checks = 0, errors = 0;
  bit            mbits[$];
  bit            mload = 0, mcommit = 0, mloaded = 0, merr = 0;
  int            msel[NO];
  logic [NO-1:0] mlut = '0;
  interconnect_matrix #(.NUM_SRC(NS), .NUM_OUT(NO), .SEL_W(SW)) dut (
    .clk_i(clk), .rst_b_i(rst_b), .cfg_start_i(start), .cfg_valid_i(valid),
    .cfg_bit_i(bitv), .cfg_ready_o(ready), .cfg_done_o(done), .cfg_err_o(err),
    .route_en_i(ren), .src_in_i(src), .lut_inp_o(lut)
  );
  always #5 clk = ~clk;
  // Model works on the list of received bits and per-channel integer selectors.
  task automatic tick(input logic s, input logic v, input logic b);
    exp_t e;
    logic [NO-1:0] nl;
    @(negedge clk);
    rst_b = g_rst; ren = g_ren; start = s; valid = v; bitv = b;
    src = NS'({$urandom, $urandom});
    if (!g_rst) begin
      mbits.delete();
      mload = 0; mcommit = 0; mloaded = 0; merr = 0; mlut = '0;
      for (int k = 0; k < NO; k++) msel[k] = 0;
    end else begin
      for (int k = 0; k < NO; k++)
        nl[k] = !mloaded ? 1'b0 : !g_ren ? mlut[k] : (msel[k] < NS ? src[msel[k]] : 1'b0);
      mlut = nl;
      if (mcommit) begin
        for (int k = 0; k < NO; k++) begin
          msel[k] = 0;
          for (int i = 0; i < SW; i++)
            msel[k] = msel[k] + (int'(mbits[TW-1-(k*SW+i)]) << i);
          if (msel[k] >= NS) merr = 1;
        end
        mloaded = 1; mcommit = 0;
      end else if (s) begin
        mbits.delete(); mload = 1; merr = 0;
      end else if (mload && v) begin
        mbits.push_back(b);
        if (mbits.size() == TW) begin mload = 0; mcommit = 1; end
      end
    end
    e = {mlut, mload, mcommit, merr};
    @(posedge clk);
    expq.push_back(e);
  endtask
  task automatic load(input int s3, input int s2, input int s1, input int s0, input int gap, input int cut);
    logic [TW-1:0] w;
    int i, n;
    logic v;
    w = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    tick(1'b1, 1'b0, 1'b0);
    i = 0; n = 0;
    while (i < cut) begin
      v = gap == 0 ? 1'b1 : gap == 1 ? (n % 3 != 2) : 1'($urandom_range(0, 1));
      tick(1'b0, v, v ? w[TW-1-i] : 1'($urandom_range(0, 1)));
      if (v) i++;
      n++;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
  always @(negedge clk) begin
    exp_t e, got;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      got = {lut, ready, done, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got lut=%b rdy=%b done=%b err=%b want lut=%b rdy=%b done=%b err=%b",
                 $time, got[NO+2:3], got[2], got[1], got[0], e[NO+2:3], e[2], e[1], e[0]);
      end
    end
  end
  initial begin
    g_rst = 1'b0; g_ren = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    g_rst = 1'b1;
    idle(50);
    load(39, 16, 24, 0, 1, TW);
    idle(20);
    load(5, 7, 45, 1, 0, TW);
    idle(15);
    load(1, 2, 3, 4, 2, TW);
    idle(10);
    load(10, 20, 30, 0, 0, 10);
    load(33, 34, 35, 36, 0, TW);
    idle(10);
    load(11, 12, 13, 14, 0, 10);
    g_rst = 1'b0;
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    g_rst = 1'b1;
    idle(10);
    load(2, 3, 4, 5, 0, TW);
    idle(5);
    g_ren = 1'b0;
    idle(10);
    g_ren = 1'b1;
    idle(5);
    repeat (30) begin
      load($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 2), $urandom_range(0, 5) == 0 ? $urandom_range(1, TW - 1) : TW);
      g_ren = $urandom_range(0, 4) != 0;
      idle($urandom_range(0, 6));
      g_ren = 1'b1;
    end
    repeat (1500) begin
      g_ren = $urandom_range(0, 9) != 0;
      g_rst = $urandom_range(0, 299) != 0;
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
    end
    g_rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
